alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter: DEPTH, 4, operation-queue depth in entries; power of two, minimum 2.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 Port: in_valid  input  1  upstream operation present.
REQ-005 Port: in_ready  output  1  block can accept an operation this cycle.
REQ-006 Port: in_a  input  4  operand A.
REQ-007 Port: in_b  input  4  operand B.
REQ-008 Port: in_sel  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT A; 101-111 illegal.
REQ-009 Port: alu_a  output  4  registered operand A to the downstream ALU.
REQ-010 Port: alu_b  output  4  registered operand B to the downstream ALU.
REQ-011 Port: alu_sel  output  3  registered opcode to the downstream ALU.
REQ-012 Port: alu_out  input  4  combinational ALU result for the current alu_a/alu_b/alu_sel.
REQ-013 Port: out_valid  output  1  captured result available.
REQ-014 Port: out_ready  input  1  consumer accepts result.
REQ-015 Port: out_result  output  4  captured result.
REQ-016 Port: out_err  output  1  result came from an illegal opcode.
REQ-017 Port: out_zero  output  1  out_result == 4'h0.
REQ-018 Port: fifo_count  output  $clog2(DEPTH)+1  queued operations, excluding the one in execution.

Function
REQ-019 Push: an operation {in_a,in_b,in_sel} SHALL be written to the FIFO tail on every edge where in_valid && in_ready.
REQ-020 in_ready SHALL equal (fifo_count < DEPTH); there is no bypass path, so a full FIFO SHALL refuse input even when a pop occurs in the same cycle.
REQ-021 FSM states SHALL be IDLE, EXEC, and HOLD.
REQ-022 IDLE: if the FIFO is not empty, pop the head into alu_a/alu_b/alu_sel and go to EXEC; otherwise remain in IDLE.
REQ-023 EXEC (exactly 1 cycle): capture alu_out into out_result, set out_valid=1, and go to HOLD; for an illegal in_sel, capture 4'h0 with out_err=1 instead of alu_out.
REQ-024 HOLD: out_result, out_err, out_zero, and out_valid SHALL remain stable until out_valid && out_ready.
REQ-025 On that handshake: clear out_valid; if the FIFO is not empty, pop and go to EXEC, otherwise go to IDLE.
REQ-026 Latency: an operation accepted into an empty FIFO with the FSM in IDLE SHALL raise out_valid on the 2nd rising edge after acceptance.
REQ-027 Throughput: at most one result per 2 cycles.
REQ-028 Results SHALL leave in acceptance order.
REQ-029 alu_* outputs SHALL hold their last popped values outside EXEC.
REQ-030 A push and a pop in the same cycle SHALL leave fifo_count unchanged.
REQ-031 FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-032 Arithmetic SHALL be 4-bit modulo-16 as produced by the ALU; the block SHALL NOT alter alu_out.
REQ-033 out_zero SHALL be registered together with out_result.

Reset
REQ-034 When rst_n=0 at a rising edge, the block SHALL: enter IDLE; set fifo_count=0 and both pointers to 0; set out_valid=0, out_result=0, out_err=0, out_zero=0; set alu_a=0, alu_b=0, alu_sel=0.
REQ-035 in_ready SHALL be 1 from the first edge after reset release.
REQ-036 Reset mid-operation SHALL discard queued and executing operations with no output handshake.

Verification
REQ-037 Reset: hold rst_n=0 for 2 cycles -> all outputs 0 except in_ready=1; fifo_count=0.
REQ-038 Single op: A=3, B=1, sel=000, out_ready=1 -> out_valid 2 edges after accept, out_result=4, out_zero=0, out_err=0.
REQ-039 Stream: A=3, B=1, sel 000..100 back-to-back, out_ready=1 -> results 4, 2, 1, 3, C in order.
REQ-040 Backpressure and wrap: out_ready=0, push ops until in_ready=0 -> 5 accepted, fifo_count=4; raise out_ready -> 5 results in order; A=F, B=1, ADD -> result 0 with out_zero=1.
REQ-041 Illegal opcode: sel=111 -> out_result=0, out_err=1, out_zero=1; the next legal op has out_err=0.
REQ-042 Reset mid-op: in HOLD with fifo_count=2, pulse rst_n=0 for 1 cycle -> next cycle out_valid=0, fifo_count=0, and no stale results appear afterwards.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Handshake bundle between the operation sequencer, its upstream producer,
// the downstream combinational ALU and the result consumer.
interface alu_op_sequencer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_a;
    logic [3:0]    in_b;
    logic [2:0]    in_sel;

    logic [3:0]    alu_a;
    logic [3:0]    alu_b;
    logic [2:0]    alu_sel;
    logic [3:0]    alu_out;

    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_result;
    logic          out_err;
    logic          out_zero;

    logic [CW-1:0] fifo_count;

    // The sequencer itself.
    modport slave (
        input  in_valid, in_a, in_b, in_sel, alu_out, out_ready,
        output in_ready, alu_a, alu_b, alu_sel,
               out_valid, out_result, out_err, out_zero, fifo_count
    );

    // The environment: producer, ALU and consumer together.
    modport master (
        output in_valid, in_a, in_b, in_sel, alu_out, out_ready,
        input  in_ready, alu_a, alu_b, alu_sel,
               out_valid, out_result, out_err, out_zero, fifo_count
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Queues ALU operations, issues them one at a time to an external ALU and
// holds each captured result until the consumer takes it.
module alu_op_sequencer #(
    parameter int DEPTH = 4
) (
    input logic               clk,
    input logic               rst_n,
    alu_op_sequencer_if.slave bus
);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int OPW = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [OPW-1:0] mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [3:0]     alu_a_q, alu_a_d;
    logic [3:0]     alu_b_q, alu_b_d;
    logic [2:0]     alu_sel_q, alu_sel_d;
    logic           out_valid_q, out_valid_d;
    logic [3:0]     out_result_q, out_result_d;
    logic           out_err_q, out_err_d;
    logic           out_zero_q, out_zero_d;

    logic           push;
    logic           pop;
    logic           fifo_empty;
    logic [OPW-1:0] head;

    // No bypass: readiness depends only on the registered occupancy.
    assign bus.in_ready = (count_q < CW'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready;
    assign fifo_empty   = (count_q == '0);
    assign head         = mem_q[rd_ptr_q];

    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_sel    = alu_sel_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_err    = out_err_q;
    assign bus.out_zero   = out_zero_q;
    assign bus.fifo_count = count_q;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_err_d    = out_err_q;
        out_zero_d   = out_zero_q;
        pop          = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // Opcodes 101..111 have no ALU meaning; report them as errors.
                if (alu_sel_q > 3'd4) begin
                    out_result_d = 4'h0;
                    out_err_d    = 1'b1;
                end else begin
                    out_result_d = bus.alu_out;
                    out_err_d    = 1'b0;
                end
                out_zero_d  = (out_result_d == 4'h0);
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            {alu_a_d, alu_b_d, alu_sel_d} = head;
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_err_q    <= 1'b0;
            out_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_err_q    <= out_err_d;
            out_zero_q   <= out_zero_d;
        end
    end

    // Queue storage carries no reset; only the pointers define its contents.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= {bus.in_a, bus.in_b, bus.in_sel};
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed and randomized checks of alu_op_sequencer against a queue-based
// reference model; the bench also plays the role of the downstream ALU.
module tb_alu_op_sequencer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.DEPTH(DEPTH)) bus ();

    alu_op_sequencer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Combinational ALU; illegal opcodes give a nonzero value the DUT must discard.
    always_comb begin
        case (bus.alu_sel)
            3'd0:    bus.alu_out = bus.alu_a + bus.alu_b;
            3'd1:    bus.alu_out = bus.alu_a - bus.alu_b;
            3'd2:    bus.alu_out = bus.alu_a & bus.alu_b;
            3'd3:    bus.alu_out = bus.alu_a | bus.alu_b;
            3'd4:    bus.alu_out = ~bus.alu_a;
            default: bus.alu_out = 4'h9;
        endcase
    end

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         last_hs = -1;
    int         last_acc = -1;
    int         rise_cyc = -1;
    logic       prev_valid = 1'b0;
    logic       acc_flag = 1'b0;
    logic       held_v = 1'b0;
    logic [3:0] held_res;
    logic       held_err;
    logic       held_zero;
    logic [4:0] exp_q [$];
    logic [4:0] out_log [$];

    // Expected {err, result} from the opcode rules, in plain integer arithmetic.
    function automatic logic [4:0] ref_op(input int a, input int b, input int sel);
        int   r;
        logic e;
        e = 1'b0;
        case (sel)
            0:       r = (a + b) % 16;
            1:       r = (a - b + 16) % 16;
            2:       r = a & b;
            3:       r = a | b;
            4:       r = 15 - a;
            default: begin r = 0; e = 1'b1; end
        endcase
        return {e, 4'(r)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample just after the falling edge, then advance.
    task automatic cycle();
        logic [4:0] e;
        #1;
        acc_flag = 1'b0;
        if (held_v) begin
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_result", bus.out_result, held_res);
            chk("hold_err", bus.out_err, held_err);
            chk("hold_zero", bus.out_zero, held_zero);
        end
        if (bus.out_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = bus.out_valid;
        if (bus.out_valid && bus.out_ready) begin
            out_log.push_back({bus.out_err, bus.out_result});
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", bus.out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_result", bus.out_result, e[3:0]);
                chk("out_err", bus.out_err, e[4]);
                chk("out_zero", bus.out_zero, e[3:0] == 4'h0);
            end
            if (last_hs >= 0) chk("throughput", (cyc - last_hs) >= 2, 1);
            last_hs = cyc;
        end
        held_v    = bus.out_valid && !bus.out_ready;
        held_res  = bus.out_result;
        held_err  = bus.out_err;
        held_zero = bus.out_zero;
        if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(ref_op(bus.in_a, bus.in_b, bus.in_sel));
            acc_flag = 1'b1;
            last_acc = cyc;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic push_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        int budget;
        budget = 20;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sel   = s;
        acc_flag     = 1'b0;
        while (!acc_flag && budget > 0) begin
            cycle();
            budget--;
        end
        bus.in_valid = 1'b0;
        chk("push_timeout", acc_flag, 1);
    endtask

    task automatic drain(input int budget);
        while (exp_q.size() > 0 && budget > 0) begin
            cycle();
            budget--;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic do_reset(input int n);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        exp_q.delete();
        held_v     = 1'b0;
        prev_valid = 1'b0;
        last_hs    = -1;
    endtask

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sel    = '0;
        bus.out_ready = 1'b0;

        // Reset state.
        do_reset(2);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_result", bus.out_result, 0);
        chk("rst_out_err", bus.out_err, 0);
        chk("rst_out_zero", bus.out_zero, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_alu_b", bus.alu_b, 0);
        chk("rst_alu_sel", bus.alu_sel, 0);
        chk("rst_fifo_count", bus.fifo_count, 0);
        chk("rst_in_ready", bus.in_ready, 1);

        // Single op and its latency.
        bus.out_ready = 1'b1;
        rise_cyc = -1;
        push_op(4'd3, 4'd1, 3'b000);
        n = 0;
        while (rise_cyc < 0 && n < 10) begin
            cycle();
            n++;
        end
        chk("latency", rise_cyc - last_acc, 3);
        drain(10);

        // Back-to-back stream through every legal opcode.
        out_log.delete();
        for (int s = 0; s < 5; s++) push_op(4'd3, 4'd1, 3'(s));
        drain(30);
        chk("stream_len", out_log.size(), 5);
        if (out_log.size() >= 5) begin
            chk("stream_add", out_log[0], 5'h04);
            chk("stream_sub", out_log[1], 5'h02);
            chk("stream_and", out_log[2], 5'h01);
            chk("stream_or", out_log[3], 5'h03);
            chk("stream_not", out_log[4], 5'h0C);
        end

        // Backpressure: fill until refused, including an overflow-to-zero add.
        bus.out_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!bus.in_ready) break;
            bus.in_valid = 1'b1;
            if (i == 2) begin
                bus.in_a = 4'hF; bus.in_b = 4'h1; bus.in_sel = 3'b000;
            end else begin
                bus.in_a = 4'($urandom); bus.in_b = 4'($urandom);
                bus.in_sel = 3'($urandom_range(0, 4));
            end
            cycle();
            if (acc_flag) n++;
        end
        bus.in_valid = 1'b0;
        chk("bp_accepted", n, 5);
        chk("bp_fifo_count", bus.fifo_count, 4);
        chk("bp_out_valid", bus.out_valid, 1);
        // Full FIFO must refuse input even while a pop is about to happen.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        #1;
        chk("full_no_bypass", bus.in_ready, 0);
        cycle();
        bus.in_valid = 1'b0;
        drain(40);

        // Illegal opcode followed by a legal one.
        out_log.delete();
        push_op(4'd5, 4'd6, 3'b111);
        push_op(4'd2, 4'd2, 3'b000);
        drain(20);
        chk("illegal_len", out_log.size(), 2);
        if (out_log.size() >= 2) begin
            chk("illegal_result", out_log[0], 5'h10);
            chk("legal_after", out_log[1], 5'h04);
        end

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            bus.in_valid  = 1'($urandom);
            bus.in_a      = 4'($urandom);
            bus.in_b      = 4'($urandom);
            bus.in_sel    = 3'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain(60);

        // Reset while holding a result with two ops queued.
        bus.out_ready = 1'b0;
        push_op(4'd1, 4'd1, 3'b000);
        push_op(4'd2, 4'd1, 3'b001);
        push_op(4'd7, 4'd8, 3'b011);
        cycle();
        cycle();
        chk("pre_rst_fifo_count", bus.fifo_count, 2);
        chk("pre_rst_out_valid", bus.out_valid, 1);
        do_reset(1);
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_fifo_count", bus.fifo_count, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        out_log.delete();
        bus.out_ready = 1'b1;
        repeat (12) cycle();
        chk("no_stale_results", out_log.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end
endmodule
